// File: rtl/sti_sched_pkg.sv
// Shared definitions for the STI_DAC command scheduler.
//   - state_t   : scheduler FSM states
//   - cmd field : bit offsets inside a 21-bit requester command word
//   - exp_bits  : number of serial bits a command of a given length produces
package sti_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_XFER = 3'd2,
    S_GAP  = 3'd3,
    S_END  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam int CMD_W    = 21;
  localparam int DATA_MSB = 20;
  localparam int DATA_LSB = 5;
  localparam int LEN_MSB  = 4;
  localparam int LEN_LSB  = 3;
  localparam int FILL_BIT = 2;
  localparam int MSB_BIT  = 1;
  localparam int LOW_BIT  = 0;

  // 8*(len+1); len+1 is widened to 3 bits so len=3 gives 32, not 0.
  function automatic logic [5:0] exp_bits(input logic [1:0] len);
    return {3'(len) + 3'd1, 3'b000};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock, asynchronous active-high reset
//   req        : per-requester request
//   accept     : the current grant was taken; advance the pointer
//   gnt        : one-hot grant (combinational), zero when nothing requests
// The pointer resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_gnt;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_gnt <= 1'b1;
    else if (accept) last_gnt <= gnt[1];
  end

endmodule

// File: rtl/sti_dac_sched.sv
// Command scheduler in front of the STI_DAC serializer.
// Arbitrates two command sources, latches the winner onto the serializer
// parallel inputs, pulses load, checks the so_valid burst length, and once
// both sources have sent their last command issues pi_end and waits for
// oem_finish.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is combinational)
//   req0_cmd, req1_cmd  : {data[15:0], length[1:0], fill, msb, low}
//   req_last            : final-command marker, sampled on handshake
//   load, pi_*          : registered serializer controls
//   so_valid            : serializer bit strobe
//   oem_finish          : serializer memory-init complete (honoured in END only)
//   busy, grant_id      : activity and owner of the current transfer
//   done, err           : sticky completion / protocol-error flags
module sti_dac_sched
  import sti_sched_pkg::*;
#(
  parameter int START_TO = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [20:0] req0_cmd,
  input  logic [20:0] req1_cmd,
  input  logic [1:0]  req_last,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  input  logic        so_valid,
  input  logic        oem_finish,
  output logic        busy,
  output logic        grant_id,
  output logic        done,
  output logic        err
);

  state_t      state, state_nx;
  logic [1:0]  fin, fin_nx;
  logic [5:0]  bit_cnt, bit_cnt_nx;
  logic [15:0] wait_cnt, wait_cnt_nx;
  logic [1:0]  gnt;
  logic        offer, hs, win, win_last;
  logic [20:0] win_cmd;
  logic [5:0]  target;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid & ~fin),
    .accept (hs),
    .gnt    (gnt)
  );

  // Ready is offered only from IDLE while some requester is still unfinished;
  // gating with reset keeps ready low while reset is held.
  assign offer     = (state == S_IDLE) && (fin != 2'b11) && !reset;
  assign req_ready = offer ? gnt : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign win       = req_ready[1];
  assign win_cmd   = win ? req1_cmd : req0_cmd;
  assign win_last  = win ? req_last[1] : req_last[0];
  assign target    = exp_bits(pi_length);

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);
  assign err  = (state == S_ERR);

  always_comb begin
    state_nx    = state;
    fin_nx      = fin;
    bit_cnt_nx  = bit_cnt;
    wait_cnt_nx = wait_cnt;
    case (state)
      S_IDLE: begin
        if (fin == 2'b11) begin
          state_nx = S_END;
        end else if (hs) begin
          state_nx = S_LOAD;
          if (win_last) fin_nx = fin | (win ? 2'b10 : 2'b01);
        end
      end
      S_LOAD: begin
        bit_cnt_nx  = '0;
        wait_cnt_nx = '0;
        state_nx    = S_XFER;
      end
      S_XFER: begin
        if (so_valid) begin
          // A strobe beyond the expected count is an overrun.
          if (bit_cnt == target) state_nx = S_ERR;
          else                   bit_cnt_nx = bit_cnt + 6'd1;
        end else if (bit_cnt != 6'd0) begin
          // Falling edge of the burst: length must match exactly.
          state_nx = (bit_cnt == target) ? S_GAP : S_ERR;
        end else if (int'(wait_cnt) + 2 >= START_TO) begin
          // wait_cnt+1 strobe-less XFER cycles plus the load cycle have
          // elapsed; entering ERR on this edge makes err visible exactly
          // START_TO cycles after the load cycle.
          state_nx = S_ERR;
        end else begin
          wait_cnt_nx = wait_cnt + 16'd1;
        end
      end
      S_GAP:   state_nx = S_IDLE;
      S_END:   if (oem_finish) state_nx = S_DONE;
      S_DONE:  state_nx = S_DONE;
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      fin       <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      load      <= 1'b0;
      pi_end    <= 1'b0;
      pi_data   <= '0;
      pi_length <= '0;
      pi_fill   <= 1'b0;
      pi_msb    <= 1'b0;
      pi_low    <= 1'b0;
      grant_id  <= 1'b0;
    end else begin
      state    <= state_nx;
      fin      <= fin_nx;
      bit_cnt  <= bit_cnt_nx;
      wait_cnt <= wait_cnt_nx;
      load     <= (state_nx == S_LOAD);
      pi_end   <= (state_nx == S_END) || (state_nx == S_DONE);
      // Serializer inputs change only on a capture, so they stay stable
      // for the whole burst.
      if (hs) begin
        pi_data   <= win_cmd[DATA_MSB:DATA_LSB];
        pi_length <= win_cmd[LEN_MSB:LEN_LSB];
        pi_fill   <= win_cmd[FILL_BIT];
        pi_msb    <= win_cmd[MSB_BIT];
        pi_low    <= win_cmd[LOW_BIT];
        grant_id  <= win;
      end
    end
  end

endmodule

// File: tb/tb_sti_dac_sched.sv
module tb_sti_dac_sched;

  localparam int START_TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_last;
  logic [20:0] req0_cmd, req1_cmd;
  logic        load, pi_fill, pi_msb, pi_low, pi_end;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        so_valid, oem_finish;
  logic        busy, grant_id, done, err;

  sti_dac_sched #(.START_TO(START_TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd), .req_last(req_last),
    .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .so_valid(so_valid), .oem_finish(oem_finish),
    .busy(busy), .grant_id(grant_id), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [20:0] cmd;
    logic        last;
  } cmd_t;

  typedef struct {
    int          rq;
    logic [20:0] cmd;
    int          bits;
    logic        exp_err;
  } vec_t;

  cmd_t        cq0[$], cq1[$];
  logic [21:0] sb[$];
  int          gnt_log[$];
  bit          hold0, hold1;
  int          n_checks = 0, n_fail = 0;
  int          n_loads = 0, n_gnt0 = 0, bits_seen = 0, ser_bits = 8, load_cyc = 0;
  bit          ser_busy = 1'b0, aborted = 1'b0;
  logic [21:0] cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic logic [20:0] mk(input logic [15:0] d, input logic [1:0] l,
                                     input logic f, input logic m, input logic lo);
    return {d, l, f, m, lo};
  endfunction

  // Requester driver: presents queue heads, records accepted commands.
  initial begin
    req_valid = '0; req_last = '0; req0_cmd = '0; req1_cmd = '0;
    forever begin
      @(posedge clk); #1;
      if (cq0.size() > 0) begin
        req_valid[0] = 1'b1; req0_cmd = cq0[0].cmd; req_last[0] = cq0[0].last;
      end else begin
        req_valid[0] = hold0; req0_cmd = '0; req_last[0] = 1'b0;
      end
      if (cq1.size() > 0) begin
        req_valid[1] = 1'b1; req1_cmd = cq1[0].cmd; req_last[1] = cq1[0].last;
      end else begin
        req_valid[1] = hold1; req1_cmd = '0; req_last[1] = 1'b0;
      end
      #2;
      if (req_ready[0] && req_valid[0]) begin
        if (cq0.size() > 0) begin
          sb.push_back({1'b0, cq0[0].cmd});
          void'(cq0.pop_front());
        end else begin
          n_checks++; n_fail++;
          $display("FAIL regrant0: req_ready[0]=1 for a finished requester, expected 0");
        end
      end
      if (req_ready[1] && req_valid[1]) begin
        if (cq1.size() > 0) begin
          sb.push_back({1'b1, cq1[0].cmd});
          void'(cq1.pop_front());
        end else begin
          n_checks++; n_fail++;
          $display("FAIL regrant1: req_ready[1]=1 for a finished requester, expected 0");
        end
      end
    end
  end

  // Serializer model and scoreboard monitor: on load, pop the expected
  // command, then strobe so_valid ser_bits times while checking pi_* hold.
  initial begin
    so_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset && load) begin
        n_loads++;
        load_cyc  = cyc;
        bits_seen = 0;
        gnt_log.push_back(int'(grant_id));
        if (grant_id == 1'b0) n_gnt0++;
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL load_unexpected: load=1 with no accepted command, expected 0");
          cur = '0;
        end else begin
          cur = sb.pop_front();
          check("sb_grant_id", 32'(grant_id), 32'(cur[21]));
          check("sb_pi_fields", 32'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 32'(cur[20:0]));
        end
        ser_busy = 1'b1;
        aborted  = 1'b0;
        for (int b = 0; b < ser_bits; b++) begin
          @(posedge clk); #1;
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          check("pi_hold", 32'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 32'(cur[20:0]));
          so_valid  = 1'b1;
          bits_seen = b + 1;
        end
        if (!aborted) begin
          @(posedge clk); #1;
        end
        so_valid = 1'b0;
        ser_busy = 1'b0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    cq0.delete(); cq1.delete(); sb.delete(); gnt_log.delete();
    hold0 = 1'b0; hold1 = 1'b0; oem_finish = 1'b0;
    n_gnt0 = 0; bits_seen = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_settle(input string name, input int budget);
    int n;
    n = 0;
    forever begin
      @(posedge clk); #2;
      if (!ser_busy && cq0.size() == 0 && cq1.size() == 0 && sb.size() == 0 && (!busy || err))
        break;
      n++;
      if (n >= budget) begin
        timeout_fail(name);
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load"},      32'(load), 32'd0);
    check({tag, "_pi_data"},   32'(pi_data), 32'd0);
    check({tag, "_pi_length"}, 32'(pi_length), 32'd0);
    check({tag, "_pi_flags"},  32'({pi_fill, pi_msb, pi_low}), 32'd0);
    check({tag, "_pi_end"},    32'(pi_end), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_grant_id"},  32'(grant_id), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_err"},       32'(err), 32'd0);
  endtask

  vec_t vt[7];

  initial begin
    int l0, lc, ec, saw;
    bit hit;

    vt[0] = '{0, mk(16'hA5C3, 2'd1, 1'b0, 1'b1, 1'b0), 16, 1'b0};
    vt[1] = '{1, mk(16'h1234, 2'd0, 1'b1, 1'b0, 1'b1),  8, 1'b0};
    vt[2] = '{0, mk(16'hFFFF, 2'd3, 1'b1, 1'b1, 1'b1), 32, 1'b0};
    vt[3] = '{1, mk(16'h0000, 2'd2, 1'b0, 1'b0, 1'b0), 24, 1'b0};
    vt[4] = '{0, mk(16'h8001, 2'd0, 1'b0, 1'b1, 1'b1),  9, 1'b1};  // overrun
    vt[5] = '{1, mk(16'h5A5A, 2'd1, 1'b0, 1'b0, 1'b0), 15, 1'b1};  // early drop
    vt[6] = '{0, mk(16'h0F0F, 2'd0, 1'b0, 1'b1, 1'b0),  8, 1'b0};

    // Reset state, with both requesters asserting valid during reset.
    reset = 1'b1; oem_finish = 1'b0; hold0 = 1'b1; hold1 = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    hold0 = 1'b0; hold1 = 1'b0;
    @(posedge clk); #2 reset = 1'b0;

    // oem_finish outside END is ignored.
    @(posedge clk); #2 oem_finish = 1'b1;
    @(posedge clk); #2 oem_finish = 1'b0;
    @(posedge clk); #2;
    check("early_finish_done", 32'(done), 32'd0);
    check("early_finish_pi_end", 32'(pi_end), 32'd0);

    // Table-driven single commands.
    for (int i = 0; i < 7; i++) begin
      ser_bits = vt[i].bits;
      l0 = n_loads;
      if (vt[i].rq == 0) cq0.push_back('{vt[i].cmd, 1'b0});
      else               cq1.push_back('{vt[i].cmd, 1'b0});
      wait_settle($sformatf("vec%0d_settle", i), 200);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].exp_err));
      check($sformatf("vec%0d_loads", i), 32'(n_loads - l0), 32'd1);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_err));
      if (err) do_reset();
    end

    // Alternating grants with both requesters continuously valid.
    do_reset();
    ser_bits = 8;
    l0 = n_loads;
    for (int k = 0; k < 4; k++) begin
      cq0.push_back('{mk(16'h1000 + 16'(k), 2'd0, 1'b0, 1'b1, 1'b0), 1'b0});
      cq1.push_back('{mk(16'h2000 + 16'(k), 2'd0, 1'b1, 1'b0, 1'b0), 1'b0});
    end
    wait_settle("alt_settle", 400);
    check("alt_loads", 32'(n_loads - l0), 32'd8);
    check("alt_err", 32'(err), 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k < gnt_log.size()) check($sformatf("alt_order%0d", k), 32'(gnt_log[k]), 32'(k % 2));
      else                    timeout_fail($sformatf("alt_order%0d", k));
    end

    // Last commands: req0 finishes first, req1 after three; then END/DONE.
    do_reset();
    ser_bits = 8;
    l0 = n_loads;
    hold0 = 1'b1;
    cq0.push_back('{mk(16'hAAAA, 2'd0, 1'b0, 1'b0, 1'b0), 1'b1});
    cq1.push_back('{mk(16'hB001, 2'd0, 1'b0, 1'b0, 1'b0), 1'b0});
    cq1.push_back('{mk(16'hB002, 2'd0, 1'b0, 1'b0, 1'b0), 1'b0});
    cq1.push_back('{mk(16'hB003, 2'd0, 1'b0, 1'b0, 1'b0), 1'b1});
    hit = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #2;
      if (pi_end) begin hit = 1'b1; break; end
    end
    if (!hit) timeout_fail("end_wait");
    check("end_pi_end", 32'(pi_end), 32'd1);
    check("end_busy", 32'(busy), 32'd1);
    check("end_done", 32'(done), 32'd0);
    check("end_loads", 32'(n_loads - l0), 32'd4);
    check("end_req0_grants", 32'(n_gnt0), 32'd1);
    check("end_first_grant", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 32'd0);
    check("end_req_ready", 32'(req_ready), 32'd0);
    oem_finish = 1'b1;
    @(posedge clk); #2 oem_finish = 1'b0;
    check("fin_done", 32'(done), 32'd1);
    check("fin_pi_end", 32'(pi_end), 32'd1);
    check("fin_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    check("fin_done_sticky", 32'(done), 32'd1);
    check("fin_req_ready", 32'(req_ready), 32'd0);
    check("fin_req0_grants", 32'(n_gnt0), 32'd1);

    // len=3 burst dropped after 20 bits; no further ready afterwards.
    do_reset();
    ser_bits = 20;
    l0 = n_loads;
    cq0.push_back('{mk(16'hC0DE, 2'd3, 1'b0, 1'b1, 1'b0), 1'b0});
    wait_settle("drop_settle", 200);
    check("drop_err", 32'(err), 32'd1);
    cq1.push_back('{mk(16'h0101, 2'd0, 1'b0, 1'b0, 1'b0), 1'b0});
    saw = 0;
    repeat (6) begin
      @(posedge clk); #2;
      if (req_ready != 2'b00 || load) saw++;
    end
    check("drop_no_ready", 32'(saw), 32'd0);
    check("drop_loads", 32'(n_loads - l0), 32'd1);
    check("drop_err_sticky", 32'(err), 32'd1);

    // Serializer never strobes: timeout START_TO cycles after load.
    do_reset();
    ser_bits = 0;
    l0 = n_loads;
    cq1.push_back('{mk(16'h4242, 2'd0, 1'b0, 1'b0, 1'b0), 1'b0});
    hit = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #2;
      if (n_loads > l0) begin hit = 1'b1; break; end
    end
    if (!hit) timeout_fail("to_load_wait");
    lc = load_cyc;
    ec = -1;
    for (int n = 0; n < 50; n++) begin
      if (err) begin ec = cyc; break; end
      @(posedge clk); #2;
    end
    check("to_err_latency", 32'(ec - lc), 32'(START_TO));
    check("to_err", 32'(err), 32'd1);

    // Reset during bit 10 of a len=2 burst, then a normal transfer.
    do_reset();
    ser_bits = 24;
    l0 = n_loads;
    cq0.push_back('{mk(16'h3C3C, 2'd2, 1'b1, 1'b0, 1'b1), 1'b0});
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #2;
      if (n_loads > l0 && bits_seen == 10) begin hit = 1'b1; break; end
    end
    if (!hit) timeout_fail("midrst_wait");
    check("midrst_pre_data", 32'(pi_data), 32'h3C3C);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    do_reset();
    ser_bits = 8;
    l0 = n_loads;
    cq1.push_back('{mk(16'h7777, 2'd0, 1'b0, 1'b1, 1'b1), 1'b0});
    wait_settle("post_rst_settle", 200);
    check("post_rst_loads", 32'(n_loads - l0), 32'd1);
    check("post_rst_err", 32'(err), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sti_dac_sched.md
# sti_dac_sched

Two-requester command scheduler sitting in front of the STI_DAC serializer. It arbitrates round-robin between two command sources and latches the winning command onto the serializer's parallel inputs. It pulses `load`, holds the inputs stable while the serializer shifts `8*(length+1)` bits, and checks the `so_valid` burst length. Once both sources have delivered their last command, it issues `pi_end` and waits for `oem_finish`.

## Interface
- `START_TO`, default 4: maximum cycles from the `load` pulse to the first `so_valid`=1 before a timeout error.
- `clk` in 1: single clock; all logic runs on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 2: per-requester command valid.
- `req_ready` out 2: per-requester accept, combinational; a handshake is `req_valid[i] & req_ready[i]`.
- `req0_cmd`, `req1_cmd` in 21 each: [20:5] data, [4:3] length, [2] fill, [1] msb, [0] low.
- `req_last` in 2: marks a command as that requester's final one; sampled on handshake.
- `load` out 1; `pi_data` out 16; `pi_length` out 2; `pi_fill`, `pi_msb`, `pi_low`, `pi_end` out 1: serializer controls, all registered.
- `so_valid` in 1: serializer bit strobe.
- `oem_finish` in 1: serializer memory-init complete.
- `busy` out 1: high in any state except IDLE and DONE.
- `grant_id` out 1: requester that owns the current transfer.
- `done` out 1: sticky completion flag.
- `err` out 1: sticky protocol error flag.

## Operation
- States: IDLE, LOAD, XFER, GAP, END, DONE, ERR.
- IDLE:
  - Requester i is eligible when `req_valid[i]` is high and `fin[i]` is 0.
  - `req_ready` is one-hot on the winner, and only in IDLE.
  - On handshake: capture the cmd fields into the `pi_*` registers, set `grant_id`, set `fin[i]` if `req_last[i]`, and go to LOAD.
  - If `fin`==2'b11 in IDLE, go to END instead; no ready is asserted.
- Arbitration:
  - `last_gnt` resets to 1, so req0 wins the first tie.
  - On a tie, grant `!last_gnt`.
  - `last_gnt` updates on every handshake.
- LOAD: `load`=1 for exactly this one cycle; clear `bit_cnt` and `wait_cnt`; go to XFER.
- XFER:
  - `bit_cnt` (6 bits) increments on each cycle with `so_valid`=1.
  - While `bit_cnt`==0 and `so_valid`=0, `wait_cnt` increments; reaching START_TO sends the block to ERR.
  - When `so_valid` falls after at least one bit: `bit_cnt` must equal `8*(pi_length+1)`. If it does, go to GAP; otherwise go to ERR. This covers both early drop and overrun.
  - `so_valid`=1 after `bit_cnt` has reached `8*(pi_length+1)` goes to ERR immediately.
- GAP: one idle cycle so the serializer re-enters its wait state; go to IDLE.
- `pi_data`, `pi_length`, `pi_fill`, `pi_msb`, `pi_low` hold their captured values from the capture edge until the next capture. They never change during XFER.
- END: `pi_end`=1, held; when `oem_finish`=1, go to DONE.
- DONE: `done`=1, `pi_end` stays 1, `req_ready`=0; terminal until reset.
- ERR: `err`=1, `req_ready`=0, `load`=0; terminal until reset.
- A requester whose `fin` bit is set is never granted again, even if it keeps `req_valid` high.

## Timing
- Reset values: `load`=0, `pi_*`=0, `pi_end`=0, `req_ready`=0, `busy`=0, `grant_id`=0, `done`=0, `err`=0; state=IDLE, `fin`=0, `last_gnt`=1, counters=0.
- Handshake at edge T puts `load` high during cycle T+1.
- Minimum spacing between two `load` pulses is `8*(length+1)` + serializer latency + GAP + IDLE.
- Back-to-back commands: the ready for the next command is asserted in the IDLE cycle that follows GAP.
- Reset mid-XFER forces every output to its reset value asynchronously; the partial transfer is abandoned and is not reported as an error.
- `oem_finish` arriving outside END is ignored.

## Structure
- Shared package `sti_sched_pkg` holds:
  - the state enum;
  - the cmd field offsets (DATA_MSB=20, DATA_LSB=5, LEN 4:3, FILL 2, MSB 1, LOW 0);
  - the function `exp_bits(len)` = `{len+1,3'b0}`.
- Natural sub-module: `rr_arb2`, a two-way round-robin arbiter with pointer update on accept.

## Test plan
- Single req0 command, cmd data=16'hA5C3 len=1 msb=1: one `load` pulse; `pi_data` held at A5C3 for the whole burst; 16 `so_valid` cycles; return to IDLE; `err`=0.
- Both requesters valid continuously, len=0: grants alternate 0,1,0,1; each burst is 8 bits; `grant_id` matches the grant order.
- req0 last=1 on its first command, req1 sends three commands then last: req0 is never re-granted; after req1's last command the block enters END, `pi_end`=1, `oem_finish` is pulsed, `done`=1.
- len=3 command with a serializer model that drops `so_valid` after 20 bits: `err`=1, no further ready.
- Serializer model never raises `so_valid`: `err`=1 exactly START_TO cycles after the load cycle.
- Assert `reset` during bit 10 of a len=2 burst: all outputs return to their reset values immediately; after release, the next command transfers normally.
